branch_target_predictor: RTL and testbench

//  Dynamic branch predictor for the FETCH stage: a direct-mapped BHT of 2-bit saturating counters plus a tagged BTB.

---
 rtl/branch_target_predictor_pkg.sv | 25 ++
 rtl/branch_target_predictor_if.sv | 30 +++
 rtl/branch_target_predictor_table.sv | 24 ++
 rtl/branch_target_predictor.sv | 84 ++++++++
 tb/tb_branch_target_predictor.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: 2-bit direction counter
// encoding, its reset value and the saturating training rule.
package bp_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bp_ctr_t;

   localparam bp_ctr_t BP_CTR_RESET = WEAK_NT;

   function automatic bp_ctr_t sat_update(bp_ctr_t ctr, logic taken);
      bp_ctr_t next;
      next = ctr;
      if (taken) begin
         if (ctr != STRONG_T) next = bp_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != STRONG_NT) next = bp_ctr_t'(ctr - 2'd1);
      end
      return next;
   endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup, decode training and statistics signals of the branch predictor.
// master = pipeline side driving PCs/training, slave = the predictor.
interface branch_target_predictor_if #(
   parameter int unsigned PC_W = 16
);
   logic [PC_W-1:0] PC_curr;
   logic            lookup_en;
   logic            prediction;
   logic [PC_W-1:0] predicted_target;
   logic [PC_W-1:0] IF_ID_PC_curr;
   logic            wen_BHT;
   logic            actual_taken;
   logic            wen_BTB;
   logic [PC_W-1:0] branch_target;
   logic            mispredict;
   logic [15:0]     lookup_cnt;
   logic [15:0]     mispredict_cnt;

   modport master (
      output PC_curr, lookup_en, IF_ID_PC_curr, wen_BHT, actual_taken,
             wen_BTB, branch_target, mispredict,
      input  prediction, predicted_target, lookup_cnt, mispredict_cnt
   );

   modport slave (
      input  PC_curr, lookup_en, IF_ID_PC_curr, wen_BHT, actual_taken,
             wen_BTB, branch_target, mispredict,
      output prediction, predicted_target, lookup_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_target_predictor_table.sv
// Flop-based table: whole array visible combinationally, one synchronous
// write port, synchronous reset of every entry to RESET_VAL.
module bp_table #(
   parameter int unsigned     WIDTH     = 2,
   parameter int unsigned     DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wen,
   input  logic [$clog2(DEPTH)-1:0]         waddr,
   input  logic [WIDTH-1:0]                 wdata,
   output logic [DEPTH-1:0][WIDTH-1:0]      q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= {DEPTH{RESET_VAL}};
      end else if (wen) begin
         q[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BHT of 2-bit counters plus tagged BTB, looked up with the fetch
// PC and trained from decode; also counts lookups and mispredicts.
module branch_target_predictor
   import bp_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 8,
   parameter int unsigned PC_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   branch_target_predictor_if.slave  bus
);

   localparam int unsigned INDEX_W = $clog2(NUM_ENTRIES);
   localparam int unsigned TAG_W   = PC_W - INDEX_W - 1;
   localparam int unsigned BTB_W   = 1 + TAG_W + PC_W;

   logic [INDEX_W-1:0]                    idx;
   logic [INDEX_W-1:0]                    upd_idx;
   logic [TAG_W-1:0]                      tag;
   logic [TAG_W-1:0]                      upd_tag;
   logic [NUM_ENTRIES-1:0][1:0]           bht_q;
   logic [NUM_ENTRIES-1:0][BTB_W-1:0]     btb_q;
   logic [BTB_W-1:0]                      entry;
   logic [BTB_W-1:0]                      btb_wdata;
   logic [1:0]                            bht_wdata;
   logic                                  hit;
   logic                                  unused_pc_lsb;

   // PC bit 0 is always zero, so it takes part in neither index nor tag.
   assign unused_pc_lsb = bus.PC_curr[0] ^ bus.IF_ID_PC_curr[0];

   always_comb begin
      idx       = bus.PC_curr[INDEX_W:1];
      tag       = bus.PC_curr[PC_W-1:INDEX_W+1];
      upd_idx   = bus.IF_ID_PC_curr[INDEX_W:1];
      upd_tag   = bus.IF_ID_PC_curr[PC_W-1:INDEX_W+1];
      entry     = btb_q[idx];
      hit       = entry[BTB_W-1] && (entry[BTB_W-2 -: TAG_W] == tag);
      bht_wdata = sat_update(bp_ctr_t'(bht_q[upd_idx]), bus.actual_taken);
      btb_wdata = {1'b1, upd_tag, bus.branch_target};
      bus.prediction       = hit && bht_q[idx][1];
      bus.predicted_target = hit ? entry[PC_W-1:0] : '0;
   end

   bp_table #(
      .WIDTH     (2),
      .DEPTH     (NUM_ENTRIES),
      .RESET_VAL (BP_CTR_RESET)
   ) u_bht (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (bus.wen_BHT),
      .waddr (upd_idx),
      .wdata (bht_wdata),
      .q     (bht_q)
   );

   bp_table #(
      .WIDTH     (BTB_W),
      .DEPTH     (NUM_ENTRIES),
      .RESET_VAL ('0)
   ) u_btb (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (bus.wen_BTB),
      .waddr (upd_idx),
      .wdata (btb_wdata),
      .q     (btb_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.lookup_cnt     <= '0;
         bus.mispredict_cnt <= '0;
      end else begin
         if (bus.lookup_en && (bus.lookup_cnt != '1))
            bus.lookup_cnt <= bus.lookup_cnt + 16'd1;
         if (bus.mispredict && (bus.mispredict_cnt != '1))
            bus.mispredict_cnt <= bus.mispredict_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench: predictor tables and counters modelled as plain arrays
// and integers, compared against the DUT each cycle.
module tb_branch_target_predictor;

   localparam int N = 8;

   logic clk;
   logic rst_n;

   branch_target_predictor_if #(.PC_W(16)) bus ();

   branch_target_predictor #(
      .NUM_ENTRIES (N),
      .PC_W        (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int compared;
   int mismatched;

   int m_ctr[N];
   bit m_valid[N];
   int m_tag[N];
   int m_tgt[N];
   int m_lk;
   int m_mp;

   function automatic int pc_idx(int pc);
      return (pc / 2) % N;
   endfunction

   function automatic int pc_tag(int pc);
      return pc / (2 * N);
   endfunction

   function automatic bit exp_pred(int pc);
      int i;
      i = pc_idx(pc);
      return m_valid[i] && (m_tag[i] == pc_tag(pc)) && (m_ctr[i] >= 2);
   endfunction

   function automatic int exp_tgt(int pc);
      int i;
      i = pc_idx(pc);
      return (m_valid[i] && (m_tag[i] == pc_tag(pc))) ? m_tgt[i] : 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_ctr[i]   = 1;
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
      end
      m_lk = 0;
      m_mp = 0;
   endtask

   // One clock edge: the model absorbs whatever the inputs present at that edge.
   task automatic tick();
      int i;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         i = pc_idx(int'(bus.IF_ID_PC_curr));
         if (bus.wen_BHT)
            m_ctr[i] = bus.actual_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
         if (bus.wen_BTB) begin
            m_valid[i] = 1;
            m_tag[i]   = pc_tag(int'(bus.IF_ID_PC_curr));
            m_tgt[i]   = int'(bus.branch_target);
         end
         if (bus.lookup_en && m_lk < 65535) m_lk++;
         if (bus.mispredict && m_mp < 65535) m_mp++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      bus.lookup_en     = 1'b0;
      bus.IF_ID_PC_curr = '0;
      bus.wen_BHT       = 1'b0;
      bus.actual_taken  = 1'b0;
      bus.wen_BTB       = 1'b0;
      bus.branch_target = '0;
      bus.mispredict    = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.PC_curr = 16'h0010;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      bus.lookup_en = 1'b1;
      #1;
      compared++;
      if (bus.prediction !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_pred: got %b want 0", bus.prediction);
      end
      compared++;
      if (bus.predicted_target !== 16'h0000) begin
         mismatched++;
         $display("FAIL reset_target: got %h want 0000", bus.predicted_target);
      end
      compared++;
      if (bus.lookup_cnt !== 16'd0 || bus.mispredict_cnt !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.lookup_cnt, bus.mispredict_cnt);
      end
      repeat (5) tick();
      bus.lookup_en = 1'b0;
      compared++;
      if (bus.lookup_cnt !== 16'd5) begin
         mismatched++;
         $display("FAIL lookup_count: got %0d want 5", bus.lookup_cnt);
      end
   endtask

   task automatic test_train();
      bus.IF_ID_PC_curr = 16'h0010;
      bus.wen_BTB       = 1'b1;
      bus.branch_target = 16'h0040;
      bus.wen_BHT       = 1'b1;
      bus.actual_taken  = 1'b1;
      tick();
      bus.wen_BTB = 1'b0;
      tick();
      bus.wen_BHT = 1'b0;
      bus.PC_curr = 16'h0010;
      #1;
      compared++;
      if (bus.prediction !== 1'b1) begin
         mismatched++;
         $display("FAIL train_pred: got %b want 1", bus.prediction);
      end
      compared++;
      if (bus.predicted_target !== 16'h0040) begin
         mismatched++;
         $display("FAIL train_target: got %h want 0040", bus.predicted_target);
      end
   endtask

   task automatic test_decay();
      bit want[6] = '{1, 0, 0, 0, 0, 1};
      bus.IF_ID_PC_curr = 16'h0010;
      bus.PC_curr       = 16'h0010;
      // Four not-taken from strong-T, then two taken: only a saturated 00 needs both to flip.
      for (int k = 0; k < 6; k++) begin
         bus.wen_BHT      = 1'b1;
         bus.actual_taken = (k >= 4);
         tick();
         bus.wen_BHT = 1'b0;
         #1;
         compared++;
         if (bus.prediction !== want[k] || bus.prediction !== exp_pred(16'h0010)) begin
            mismatched++;
            $display("FAIL decay_step%0d: got %b want %b", k, bus.prediction, want[k]);
         end
      end
   endtask

   task automatic test_alias();
      bus.IF_ID_PC_curr = 16'h0010;
      bus.wen_BHT       = 1'b1;
      bus.actual_taken  = 1'b1;
      tick();
      tick();
      bus.wen_BHT = 1'b0;
      bus.PC_curr = 16'h0020;
      #1;
      compared++;
      if (bus.prediction !== 1'b0 || bus.predicted_target !== 16'h0000) begin
         mismatched++;
         $display("FAIL alias_miss: got %b/%h want 0/0000", bus.prediction, bus.predicted_target);
      end
      bus.IF_ID_PC_curr = 16'h0020;
      bus.wen_BTB       = 1'b1;
      bus.branch_target = 16'h0080;
      tick();
      bus.wen_BTB = 1'b0;
      bus.PC_curr = 16'h0010;
      #1;
      compared++;
      if (bus.prediction !== 1'b0 || bus.predicted_target !== 16'h0000) begin
         mismatched++;
         $display("FAIL alias_evicted: got %b/%h want 0/0000", bus.prediction, bus.predicted_target);
      end
      bus.PC_curr = 16'h0020;
      #1;
      compared++;
      if (bus.prediction !== 1'b1 || bus.predicted_target !== 16'h0080) begin
         mismatched++;
         $display("FAIL alias_new: got %b/%h want 1/0080", bus.prediction, bus.predicted_target);
      end
   endtask

   task automatic test_same_cycle();
      bus.PC_curr       = 16'h0020;
      bus.IF_ID_PC_curr = 16'h0020;
      bus.wen_BTB       = 1'b1;
      bus.branch_target = 16'h00A0;
      #1;
      compared++;
      if (bus.predicted_target !== 16'h0080) begin
         mismatched++;
         $display("FAIL same_cycle_old: got %h want 0080", bus.predicted_target);
      end
      tick();
      bus.wen_BTB = 1'b0;
      #1;
      compared++;
      if (bus.predicted_target !== 16'h00A0) begin
         mismatched++;
         $display("FAIL same_cycle_new: got %h want 00A0", bus.predicted_target);
      end
      // Reset wins over training presented at the same edge.
      rst_n             = 1'b0;
      bus.IF_ID_PC_curr = 16'h0004;
      bus.wen_BTB       = 1'b1;
      bus.wen_BHT       = 1'b1;
      bus.actual_taken  = 1'b1;
      bus.branch_target = 16'h0050;
      tick();
      rst_n = 1'b1;
      bus.wen_BTB = 1'b0;
      bus.wen_BHT = 1'b0;
      bus.PC_curr = 16'h0004;
      #1;
      compared++;
      if (bus.prediction !== 1'b0 || bus.predicted_target !== 16'h0000) begin
         mismatched++;
         $display("FAIL reset_drops_write: got %b/%h want 0/0000", bus.prediction, bus.predicted_target);
      end
      // Counter back at weak-NT: one taken update plus a BTB fill gives a taken hit.
      bus.wen_BTB = 1'b1;
      bus.wen_BHT = 1'b1;
      tick();
      bus.wen_BTB = 1'b0;
      bus.wen_BHT = 1'b0;
      #1;
      compared++;
      if (bus.prediction !== 1'b1 || bus.predicted_target !== 16'h0050) begin
         mismatched++;
         $display("FAIL reset_ctr_weak_nt: got %b/%h want 1/0050", bus.prediction, bus.predicted_target);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         bus.PC_curr       = 16'(($urandom_range(0, 3) * 2 * N) + ($urandom_range(0, N - 1) * 2));
         bus.IF_ID_PC_curr = 16'(($urandom_range(0, 3) * 2 * N) + ($urandom_range(0, N - 1) * 2));
         bus.lookup_en     = 1'($urandom_range(0, 1));
         bus.wen_BHT       = 1'($urandom_range(0, 1));
         bus.actual_taken  = 1'($urandom_range(0, 1));
         bus.wen_BTB       = ($urandom_range(0, 3) == 0);
         bus.branch_target = 16'($urandom) & 16'hFFFE;
         bus.mispredict    = ($urandom_range(0, 3) == 0);
         #1;
         compared++;
         if (bus.prediction !== exp_pred(int'(bus.PC_curr)) ||
             bus.predicted_target !== 16'(exp_tgt(int'(bus.PC_curr)))) begin
            mismatched++;
            $display("FAIL random_lookup%0d: pc %h got %b/%h want %b/%h", k, bus.PC_curr,
                     bus.prediction, bus.predicted_target,
                     exp_pred(int'(bus.PC_curr)), 16'(exp_tgt(int'(bus.PC_curr))));
         end
         tick();
      end
      idle_inputs();
      #1;
      compared++;
      if (bus.lookup_cnt !== 16'(m_lk) || bus.mispredict_cnt !== 16'(m_mp)) begin
         mismatched++;
         $display("FAIL random_counts: got %0d/%0d want %0d/%0d",
                  bus.lookup_cnt, bus.mispredict_cnt, m_lk, m_mp);
      end
   endtask

   task automatic test_saturate();
      int frozen;
      frozen = m_lk;
      bus.lookup_en  = 1'b0;
      bus.mispredict = 1'b1;
      repeat (66000) tick();
      bus.mispredict = 1'b0;
      #1;
      compared++;
      if (bus.mispredict_cnt !== 16'hFFFF || m_mp != 65535) begin
         mismatched++;
         $display("FAIL mispredict_saturate: got %h want FFFF", bus.mispredict_cnt);
      end
      compared++;
      if (bus.lookup_cnt !== 16'(frozen)) begin
         mismatched++;
         $display("FAIL lookup_frozen: got %0d want %0d", bus.lookup_cnt, frozen);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      bus.PC_curr = '0;
      idle_inputs();
      model_reset();
      test_reset();
      test_train();
      test_decay();
      test_alias();
      test_same_cycle();
      test_random();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
